pwm_duty_decoder: RTL and testbench
===================================

# pwm_duty_decoder

Receive-side counterpart of the fan PWM generator: samples a single-bit PWM stream and recovers the 8-bit duty value that produced it. Measures high time and period between successive rising edges, reports the duty as `speed` with a one-cycle valid strobe, and flags period mismatches and stuck-high/stuck-low lines. Sits on the fan feedback path, so the controller can confirm that the commanded speed actually reaches the PWM pin.

## Interface
- `PERIOD`, 256: expected PWM period in clocks; equals the generator counter wrap.
- `TIMEOUT`, 512: clocks without a rising edge before the line is declared stuck; must be greater than `PERIOD`.
- `clk` input, 1 bit: single clock domain; all logic on the rising edge.
- `arst` input, 1 bit: asynchronous reset, active-low. Asserting it clears every register immediately; release is synchronous to `clk`.
- `pwm_data` input, 1 bit: PWM stream under measurement.
- `speed` output, 8 bits: last recovered duty (high cycles per period). Reset value 0.
- `speed_valid` output, 1 bit: one-cycle strobe when `speed` updates. Reset value 0.
- `period_err` output, 1 bit: one-cycle strobe when a measured period is not equal to `PERIOD`. Reset value 0.
- `stuck` output, 1 bit: level; high while the line has had no rising edge for `TIMEOUT` clocks. Reset value 0.

## Operation
- Input path: `pwm_data` passes through a sample register `s` (plus an optional synchronizer, see Configuration). A previous-value register `p` holds the prior sample. `rise = s & ~p`.
- Counters:
  - `period_cnt` is $clog2(TIMEOUT+1) bits and saturates at `TIMEOUT`.
  - `high_cnt` is the same width and saturates.
- FSM states: `S_WAIT`, `S_MEAS`, `S_STUCK`.
- `S_WAIT` (entered at reset):
  - Counts idle clocks in `period_cnt`.
  - On `rise`, load `period_cnt=1` and `high_cnt=1`, then go to `S_MEAS`. Nothing is reported for this first edge.
  - If `period_cnt` reaches `TIMEOUT`, go to `S_STUCK`.
- `S_MEAS`:
  - Each non-rise cycle: `period_cnt++`, and `high_cnt += s`.
  - On `rise` with `period_cnt == PERIOD`: `speed <= min(high_cnt,255)` and pulse `speed_valid`.
  - On `rise` with `period_cnt != PERIOD`: pulse `period_err`; `speed` is unchanged.
  - Either way, reload both counters to 1 and stay in `S_MEAS`.
  - If `period_cnt` reaches `TIMEOUT` without a rise, go to `S_STUCK`.
- `S_STUCK` entry:
  - Set `stuck=1`.
  - `speed <= s ? 255 : 0`, with one `speed_valid` pulse.
  - Stay in `S_STUCK` while there is no `rise`. No further strobes while stuck.
- `S_STUCK` exit: on `rise`, clear `stuck`, load both counters to 1, and go to `S_MEAS`. The first period after recovery is reported normally.
- A `rise` in the same cycle that `period_cnt` hits `TIMEOUT`: the rise wins and is treated as a normal period end. That period mismatches, so `period_err` pulses.
- Reset asserted mid-period: the partial measurement is discarded, all outputs go to 0, and the FSM returns to `S_WAIT`.

## Timing
- `speed`, `speed_valid`, `period_err` and `stuck` are registered outputs.
- Latency without the macro: the `pwm_data` edge is captured into `s` at clock edge N. `rise` is true during cycle N. Outputs update at clock edge N+1, i.e. 2 clocks from input transition to `speed_valid`.
- With `PWM_DEC_SYNC_EN`: add 2 clocks, for 4 in total.
- `speed_valid` and `period_err` are mutually exclusive and never asserted on consecutive cycles for a valid stream. They repeat once per `PERIOD` clocks.
- `stuck` rises `TIMEOUT` clocks after the last `rise`, plus the input latency.

## Configuration
- `PWM_DEC_SYNC_EN` defined: a two-flop synchronizer is placed ahead of `s`, for asynchronous or off-board PWM sources. Latency becomes 4 clocks.
- `PWM_DEC_SYNC_EN` undefined: `pwm_data` is registered once into `s`, for the on-chip generator in the same clock domain. Latency is 2 clocks.
- Measured values are identical in both builds; only the latency differs.

## Structure
- Shared package `pwm_pkg`:
  - `pwm_dec_state_t` enum (`S_WAIT`, `S_MEAS`, `S_STUCK`).
  - `PWM_PERIOD_DEFAULT = 256`.
  - `PWM_DUTY_W = 8`.
- Sub-module `pwm_in_sync`:
  - Contains the optional synchronizer, `s`/`p` registers and `rise` output.
  - Reused by future tachometer inputs.
- The top module holds the counters, FSM and output registers.

## Test plan
- Release `arst` after 15 ns; drive a PWM with 64 high / 192 low (period 256) → first edge gives no report. Each later rise gives `speed=64` with `speed_valid` once per 256 clocks, `period_err=0` and `stuck=0`.
- Drive 255 high / 1 low → `speed=255`. Drive 1 high / 255 low → `speed=1`.
- Hold `pwm_data=0` (generator commanded to 0) → after 512 clocks, `stuck=1` and `speed=0` with a single `speed_valid`. Hold 1 instead → `speed=255`.
- Stream with a 200-clock period (50 high) → `period_err` pulses each period and `speed` keeps its previous value.
- From the stuck state, restart a 128/256 stream → `stuck` clears on the first rise. One period later, `speed=128`.
- Assert `arst` mid-high-phase → all outputs are 0 asynchronously. After release, the first rise is unreported and the next period is reported correctly.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM receive path: decoder FSM states, default
// period/timeout and the duty width used by the fan generator and decoder.
package pwm_pkg;

    typedef enum logic [1:0] {
        S_WAIT,
        S_MEAS,
        S_STUCK
    } pwm_dec_state_t;

    localparam int PWM_PERIOD_DEFAULT  = 256;
    localparam int PWM_TIMEOUT_DEFAULT = 512;
    localparam int PWM_DUTY_W          = 8;

    // High counts beyond the duty range only appear on overlong periods.
    function automatic logic [PWM_DUTY_W-1:0] clamp_duty(input logic [31:0] v);
        return (v > 32'd255) ? '1 : v[PWM_DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: optional two-flop synchronizer (PWM_DEC_SYNC_EN),
// sample register s, previous-sample register p and rising-edge detect.
module pwm_in_sync (
    input  logic clk,
    input  logic arst,
    input  logic din,
    output logic s,
    output logic rise
);

    logic d;
    logic p;

`ifdef PWM_DEC_SYNC_EN
    logic [1:0] meta;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) meta <= '0;
        else       meta <= {meta[0], din};
    end

    assign d = meta[1];
`else
    assign d = din;
`endif

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            s <= 1'b0;
            p <= 1'b0;
        end else begin
            s <= d;
            p <= s;
        end
    end

    assign rise = s & ~p;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the 8-bit duty from a PWM stream by measuring high time and period
// between rising edges; flags period mismatch and stuck lines. PWM_DEC_SYNC_EN adds an input synchronizer.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int PERIOD  = PWM_PERIOD_DEFAULT,
    parameter int TIMEOUT = PWM_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  pwm_data,
    output logic [PWM_DUTY_W-1:0] speed,
    output logic                  speed_valid,
    output logic                  period_err,
    output logic                  stuck
);

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  PERIOD_C  = CW'(PERIOD);
    localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0]  ONE_C     = CW'(1);

    logic s;
    logic rise;

    pwm_in_sync u_in (
        .clk  (clk),
        .arst (arst),
        .din  (pwm_data),
        .s    (s),
        .rise (rise)
    );

    pwm_dec_state_t        state, state_nx;
    logic [CW-1:0]         period_cnt, period_nx;
    logic [CW-1:0]         high_cnt, high_nx;
    logic [PWM_DUTY_W-1:0] speed_nx;
    logic                  valid_nx, err_nx, stuck_nx;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= S_WAIT;
            period_cnt  <= '0;
            high_cnt    <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            period_err  <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            state       <= state_nx;
            period_cnt  <= period_nx;
            high_cnt    <= high_nx;
            speed       <= speed_nx;
            speed_valid <= valid_nx;
            period_err  <= err_nx;
            stuck       <= stuck_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        period_nx = period_cnt;
        high_nx   = high_cnt;
        speed_nx  = speed;
        valid_nx  = 1'b0;
        err_nx    = 1'b0;
        stuck_nx  = stuck;
        case (state)
            S_WAIT: begin
                if (rise) begin
                    period_nx = ONE_C;
                    high_nx   = ONE_C;
                    state_nx  = S_MEAS;
                end else if (period_cnt == TIMEOUT_C) begin
                    state_nx = S_STUCK;
                    stuck_nx = 1'b1;
                    speed_nx = s ? '1 : '0;
                    valid_nx = 1'b1;
                end else begin
                    period_nx = period_cnt + ONE_C;
                end
            end
            S_MEAS: begin
                // A rise on the timeout cycle still closes the period (as a mismatch).
                if (rise) begin
                    if (period_cnt == PERIOD_C) begin
                        speed_nx = clamp_duty(32'(high_cnt));
                        valid_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                    period_nx = ONE_C;
                    high_nx   = ONE_C;
                end else if (period_cnt == TIMEOUT_C) begin
                    state_nx = S_STUCK;
                    stuck_nx = 1'b1;
                    speed_nx = s ? '1 : '0;
                    valid_nx = 1'b1;
                end else begin
                    period_nx = period_cnt + ONE_C;
                    if (s && high_cnt != TIMEOUT_C) high_nx = high_cnt + ONE_C;
                end
            end
            S_STUCK: begin
                if (rise) begin
                    stuck_nx  = 1'b0;
                    period_nx = ONE_C;
                    high_nx   = ONE_C;
                    state_nx  = S_MEAS;
                end
            end
            default: state_nx = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed-stimulus bench for pwm_duty_decoder (default build, 2-clock latency):
// per-cycle compare against an edge-timeline model plus literal spot checks.
module tb_pwm_duty_decoder;

    localparam int PERIOD  = 256;
    localparam int TIMEOUT = 512;

    logic       clk = 1'b0;
    logic       arst;
    logic       pwm_data;
    logic [7:0] speed;
    logic       speed_valid;
    logic       period_err;
    logic       stuck;

    pwm_duty_decoder #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .arst        (arst),
        .pwm_data    (pwm_data),
        .speed       (speed),
        .speed_valid (speed_valid),
        .period_err  (period_err),
        .stuck       (stuck)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: tracks the sampled line as a timeline of rising edges. A period
    // ends at a rise; its length is the distance to the previous rise and its
    // duty is the number of high samples in between.
    logic [7:0] exp_speed = '0;
    logic       exp_valid = 1'b0;
    logic       exp_err   = 1'b0;
    logic       exp_stuck = 1'b0;

    initial begin
        bit s_m = 0, p_m = 0, measuring = 0, cur, rise;
        int cyc = 0, ref_cyc = 0, ones = 0, age;
        forever begin
            @(posedge clk or negedge arst);
            if (!arst) begin
                s_m = 0; p_m = 0; measuring = 0;
                cyc = 0; ref_cyc = 0; ones = 0;
                exp_speed = '0; exp_valid = 0; exp_err = 0; exp_stuck = 0;
            end else begin
                cur = s_m;
                rise = cur && !p_m;
                age = cyc - ref_cyc;
                exp_valid = 0;
                exp_err   = 0;
                if (rise) begin
                    if (measuring) begin
                        if (age == PERIOD) begin
                            exp_valid = 1;
                            exp_speed = (ones > 255) ? 8'd255 : 8'(ones);
                        end else begin
                            exp_err = 1;
                        end
                    end
                    measuring = 1;
                    exp_stuck = 0;
                    ref_cyc   = cyc;
                    ones      = 1;
                end else begin
                    ones += int'(cur);
                    if (!exp_stuck && age >= TIMEOUT) begin
                        exp_stuck = 1;
                        exp_speed = cur ? 8'd255 : 8'd0;
                        exp_valid = 1;
                        measuring = 0;
                    end
                end
                p_m = s_m;
                s_m = pwm_data;
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("speed",       int'(speed),       int'(exp_speed));
            chk("speed_valid", int'(speed_valid), int'(exp_valid));
            chk("period_err",  int'(period_err),  int'(exp_err));
            chk("stuck",       int'(stuck),       int'(exp_stuck));
            if (speed_valid) valid_cnt++;
            if (period_err)  err_cnt++;
        end
    end

    // Inputs change 1 ns after a rising edge and hold for n edges.
    task automatic drive(input logic v, input int n);
        pwm_data = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm(input int hi, input int lo, input int periods);
        for (int i = 0; i < periods; i++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        arst = 1'b1;
        pwm_data = 1'b0;
        #2 arst = 1'b0;
        #9;
        chk("reset_speed", int'(speed), 0);
        chk("reset_stuck", int'(stuck), 0);
        #6 arst = 1'b1;
        @(posedge clk); #1;

        valid_cnt = 0;
        pwm(64, 192, 4);
        chk("p64_speed", int'(speed), 64);
        chk("p64_valid_cnt", valid_cnt, 3);

        pwm(255, 1, 3);
        chk("p255_speed", int'(speed), 255);

        pwm(1, 255, 3);
        chk("p1_speed", int'(speed), 1);

        valid_cnt = 0;
        drive(1'b0, 600);
        chk("hold0_stuck", int'(stuck), 1);
        chk("hold0_speed", int'(speed), 0);
        chk("hold0_valid_cnt", valid_cnt, 1);

        pwm(128, 128, 3);
        chk("recover_stuck", int'(stuck), 0);
        chk("recover_speed", int'(speed), 128);

        drive(1'b1, 600);
        chk("hold1_stuck", int'(stuck), 1);
        chk("hold1_speed", int'(speed), 255);

        err_cnt = 0;
        valid_cnt = 0;
        pwm(50, 150, 4);
        chk("p200_err_cnt", err_cnt, 2);
        chk("p200_valid_cnt", valid_cnt, 0);
        chk("p200_speed", int'(speed), 255);
        chk("p200_stuck", int'(stuck), 0);

        pwm(64, 192, 2);
        drive(1'b1, 10);
        chk("pre_reset_speed", int'(speed), 64);
        arst = 1'b0;
        #1;
        chk("async_reset_speed", int'(speed), 0);
        chk("async_reset_stuck", int'(stuck), 0);
        chk("async_reset_valid", int'(speed_valid), 0);
        pwm_data = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        valid_cnt = 0;
        pwm(100, 156, 3);
        chk("post_reset_speed", int'(speed), 100);
        chk("post_reset_valid_cnt", valid_cnt, 2);

        drive(1'b0, 5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
